// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [OP_WIDTH-1:0] op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
  logic owner_q, prio_q, win, grant;
  // A lone request always wins; a tie goes to prio_q; nothing is granted while reset is held
  always_comb begin
    win = (req0_valid && req1_valid) ? prio_q : req1_valid;
    grant = state == IDLE && !reset && (req0_valid || req1_valid);
  end
  assign req0_ready = grant && !win;
  assign req1_ready = grant && win;
  assign alu_op = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign rsp0_valid = state == RESP && !owner_q;
  assign rsp1_valid = state == RESP && owner_q;
  assign rsp_data = res_q;
  assign busy = state != IDLE;
  // Accept one operation, let the ALU evaluate it for a cycle, then hold the result until its owner takes it
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      owner_q <= 1'b0;
      prio_q <= 1'b0;
    end else
      case (state)
        IDLE: if (grant) begin
          op_q <= win ? req1_op : req0_op;
          a_q <= win ? req1_a : req0_a;
          b_q <= win ? req1_b : req0_b;
          owner_q <= win;
          prio_q <= !win;
          state <= EXEC;
        end
        EXEC: begin
          res_q <= alu_result;
          state <= RESP;
        end
        RESP: if (owner_q ? rsp1_ready : rsp0_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the ALU share arbiter against a transaction-level model
module tb_alu_share_arbiter;
  logic clk = 1'b0, reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  int checks = 0, errors = 0, cyc = 0;
  int glog[$], gcyc[$];
  // transaction-level model: phase 0 free, 1 evaluating, 2 result waiting
  int phase = 0, mw;
  logic known = 1'b0, m_prio = 1'b0, m_owner = 1'b0;
  logic [3:0] m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return op == 4'd0 ? (a & b) : op == 4'd1 ? (a | b) : op == 4'd2 ? a + b :
           op == 4'd3 || op == 4'd6 ? a - b : op == 4'd7 ? 32'(a < b) : a ^ b;
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always_comb mw = (req0_valid && req1_valid) ? int'(m_prio) : req0_valid ? 0 : req1_valid ? 1 : -1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      known <= 1'b1;
      phase <= 0;
      m_prio <= 1'b0;
      m_owner <= 1'b0;
      m_op <= '0;
      m_a <= '0;
      m_b <= '0;
      m_res <= '0;
    end else if (known)
      case (phase)
        0: if (mw >= 0) begin
          m_owner <= mw == 1;
          m_prio <= mw != 1;
          m_op <= mw == 1 ? req1_op : req0_op;
          m_a <= mw == 1 ? req1_a : req0_a;
          m_b <= mw == 1 ? req1_b : req0_b;
          phase <= 1;
        end
        1: begin
          m_res <= alu_fn(m_op, m_a, m_b);
          phase <= 2;
        end
        default: if (m_owner ? rsp1_ready : rsp0_ready) phase <= 0;
      endcase
  end

  always @(negedge clk) begin
    if (req0_valid && req0_ready) begin glog.push_back(0); gcyc.push_back(cyc); end
    if (req1_valid && req1_ready) begin glog.push_back(1); gcyc.push_back(cyc); end
    if (known) begin
      chk("req0_ready", 32'(req0_ready), 32'(!reset && phase == 0 && mw == 0));
      chk("req1_ready", 32'(req1_ready), 32'(!reset && phase == 0 && mw == 1));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(phase == 2 && !m_owner));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(phase == 2 && m_owner));
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("rsp_data", rsp_data, m_res);
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
    end
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 4'd2; req1_op = 4'd3;
    req0_a = 32'd11; req0_b = 32'd22; req1_a = 32'd33; req1_b = 32'd44;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'({req0_ready, req1_ready}), 0);
      chk("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_alu_a", alu_a, 0);
    end
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step;
    // lone request on port 1: 5 + 7
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd5; req1_b = 32'd7; rsp1_ready = 1'b1;
    @(negedge clk);
    chk("single_ready1", 32'(req1_ready), 1);
    chk("single_ready0", 32'(req0_ready), 0);
    step;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("single_exec_rsp", 32'(rsp1_valid), 0);
    step;
    @(negedge clk);
    chk("single_rsp1", 32'(rsp1_valid), 1);
    chk("single_data", rsp_data, 12);
    chk("single_rsp0", 32'(rsp0_valid), 0);
    step;
    @(negedge clk);
    chk("single_done", 32'(busy), 0);
    // round robin with both requests held
    glog.delete(); gcyc.delete();
    rsp0_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (12) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      req0_op = 4'($urandom_range(0, 7)); req1_op = 4'($urandom_range(0, 7));
      step;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", glog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < glog.size()) begin
        chk("rr_grant", glog[i], i % 2);
        if (i > 0) chk("rr_interval", gcyc[i] - gcyc[i-1], 3);
      end
    // backpressure on port 0: 9 - 4 held while port 1 waits
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0011; req0_a = 32'd9; req0_b = 32'd4;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd1;
    @(negedge clk);
    chk("bp_ready0", 32'(req0_ready), 1);
    step;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("bp_exec_ready1", 32'(req1_ready), 0);
    step;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp0", 32'(rsp0_valid), 1);
      chk("bp_data", rsp_data, 5);
      chk("bp_ready1", 32'(req1_ready), 0);
      step;
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_data", rsp_data, 5);
    step;
    @(negedge clk);
    chk("bp_resume", 32'(req1_ready), 1);
    step;
    req1_valid = 1'b0;
    step;
    step;
    // reset while evaluating drops the transaction and restores tie priority to port 0
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd3; req0_b = 32'd3;
    step;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("mr_busy", 32'(busy), 1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("mr_idle", 32'(busy), 0);
    chk("mr_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    chk("mr_tie0", 32'(req0_ready), 1);
    chk("mr_tie1", 32'(req1_ready), 0);
    step;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
    step;
    step;
    // port 0 pulses valid only while port 1's result is pending
    req1_valid = 1'b1; rsp1_ready = 1'b0;
    step;
    req1_valid = 1'b0;
    step;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("wd_ready", 32'(req0_ready), 0);
    step;
    req0_valid = 1'b0; rsp1_ready = 1'b1;
    step;
    repeat (3) begin
      @(negedge clk);
      chk("wd_norsp", 32'(rsp0_valid), 0);
      step;
    end
    // randomized traffic against the model
    repeat (600) begin
      reset = $urandom_range(0, 59) == 0;
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_op = 4'($urandom_range(0, 7)); req1_op = 4'($urandom_range(0, 7));
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      rsp0_ready = $urandom_range(0, 9) < 7; rsp1_ready = $urandom_range(0, 9) < 7;
      step;
    end
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
